bbox_outline_draw: RTL and testbench

Downstream stage of the bounding-box finder. On a start pulse it takes the finished box corners (x_min, y_min, x_max, y_max) and walks the rectangle outline. It writes one colour pixel per outline position into the frame-buffer RAM through a ready/valid write port, then pulses done. The result is the detected box rendered onto the source image for inspection or VGA scan-out.

---
 rtl/bbox_pkg.sv | 28 ++
 rtl/bbox_outline_draw_if.sv | 13 +
 rtl/bbox_edge_walker.sv | 35 +++
 rtl/bbox_outline_draw.sv | 188 ++++++++++++++++++
 tb/tb_bbox_outline_draw.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/bbox_pkg.sv
// rtl/bbox_pkg.sv - shared state type, coordinate types, defaults and address helper
package bbox_pkg;

    localparam int unsigned IMG_W_DEF  = 320;
    localparam int unsigned IMG_H_DEF  = 240;
    localparam logic [23:0] COLOUR_DEF = 24'hFF0000;

    typedef logic [8:0] xcoord_t;
    typedef logic [7:0] ycoord_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TOP,
        S_BOTTOM,
        S_LEFT,
        S_RIGHT,
`ifdef BBOX_CENTRE_EN
        S_CENTRE,
`endif
        S_DONE
    } state_t;

    function automatic logic [31:0] pix_addr(input xcoord_t x, input ycoord_t y,
                                             input int unsigned img_w);
        return 32'(y) * img_w + 32'(x);
    endfunction

endpackage

// File: rtl/bbox_outline_draw_if.sv
// rtl/bbox_outline_draw_if.sv - frame-buffer write port with ready/valid handshake
interface bbox_outline_draw_if #(
    parameter int AW    = 17,
    parameter int PIX_W = 24
);
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [PIX_W-1:0] wr_data;
    logic             wr_ready;

    modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/bbox_edge_walker.sv
// rtl/bbox_edge_walker.sv - loadable coordinate counter, reloaded once per outline edge
module bbox_edge_walker
    import bbox_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_start,
    input  logic [W-1:0] load_end,
    input  logic         step,
    output logic [W-1:0] pos_next,
    output logic         last
);

    logic [W-1:0] pos;
    logic [W-1:0] end_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            pos   <= '0;
            end_r <= '0;
        end else if (load) begin
            pos   <= load_start;
            end_r <= load_end;
        end else if (step) begin
            pos   <= pos_next;
        end
    end

    assign pos_next = pos + W'(1);
    assign last     = (pos == end_r);

endmodule

// File: rtl/bbox_outline_draw.sv
// rtl/bbox_outline_draw.sv - walks a box outline into the frame buffer; BBOX_CENTRE_EN adds a centre pixel and cx/cy
module bbox_outline_draw
    import bbox_pkg::*;
#(
    parameter int unsigned      IMG_W  = IMG_W_DEF,
    parameter int unsigned      IMG_H  = IMG_H_DEF,
    parameter int               XW     = 9,
    parameter int               YW     = 8,
    parameter int               AW     = 17,
    parameter int               PIX_W  = 24,
    parameter logic [PIX_W-1:0] COLOUR = COLOUR_DEF
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          start,
    input  logic [XW-1:0] x_min,
    input  logic [XW-1:0] x_max,
    input  logic [YW-1:0] y_min,
    input  logic [YW-1:0] y_max,
    output logic          busy,
    output logic          done,
    output logic          err,
`ifdef BBOX_CENTRE_EN
    output logic [XW-1:0] cx,
    output logic [YW-1:0] cy,
`endif
    bbox_outline_draw_if.master wr
);

    localparam int CW = (XW > YW) ? XW : YW;

    state_t  state;
    xcoord_t x0, x1;
    ycoord_t y0, y1;
    ycoord_t y0_p1, y1_m1;

    logic          box_ok;
    logic          accept;
    logic          has_side;
    logic          walk_load, walk_step, walk_last;
    logic [CW-1:0] walk_start, walk_end, walk_next;

    state_t        adv_state;
    logic [CW-1:0] adv_start, adv_end;
    xcoord_t       adv_x, step_x;
    ycoord_t       adv_y, step_y;

    assign box_ok = (x_min <= x_max) && (y_min <= y_max) &&
                    (32'(x_max) < IMG_W) && (32'(y_max) < IMG_H);

    assign accept   = wr.wr_en && wr.wr_ready;
    assign y0_p1    = y0 + ycoord_t'(1);
    assign y1_m1    = y1 - ycoord_t'(1);
    assign has_side = (y1 - y0) > ycoord_t'(1);

    // The walker is loaded from the raw inputs on start, otherwise with the next edge's range.
    assign walk_load  = (state == S_IDLE) ? start : (accept && walk_last);
    assign walk_step  = (state != S_IDLE) && accept && !walk_last;
    assign walk_start = (state == S_IDLE) ? CW'(x_min) : adv_start;
    assign walk_end   = (state == S_IDLE) ? CW'(x_max) : adv_end;

    bbox_edge_walker #(.W(CW)) u_walker (
        .clk        (CLOCK_50),
        .reset      (reset),
        .load       (walk_load),
        .load_start (walk_start),
        .load_end   (walk_end),
        .step       (walk_step),
        .pos_next   (walk_next),
        .last       (walk_last)
    );

    // Next pixel inside the current edge, and the first pixel of whichever edge follows it.
    always_comb begin
        step_x    = (state == S_LEFT)  ? x0 :
                    (state == S_RIGHT) ? x1 : xcoord_t'(walk_next);
        step_y    = (state == S_TOP)    ? y0 :
                    (state == S_BOTTOM) ? y1 : ycoord_t'(walk_next);
        adv_state = S_DONE;
        adv_start = '0;
        adv_end   = '0;
        adv_x     = x0;
        adv_y     = y0;
`ifdef BBOX_CENTRE_EN
        if (state != S_CENTRE) begin
            adv_state = S_CENTRE;
            adv_x     = cx;
            adv_y     = cy;
        end
`endif
        case (state)
            S_TOP: begin
                if (y1 != y0) begin
                    adv_state = S_BOTTOM;
                    adv_start = CW'(x0);
                    adv_end   = CW'(x1);
                    adv_x     = x0;
                    adv_y     = y1;
                end
            end
            S_BOTTOM: begin
                if (has_side) begin
                    adv_state = S_LEFT;
                    adv_start = CW'(y0_p1);
                    adv_end   = CW'(y1_m1);
                    adv_x     = x0;
                    adv_y     = y0_p1;
                end
            end
            S_LEFT: begin
                if (x1 != x0) begin
                    adv_state = S_RIGHT;
                    adv_start = CW'(y0_p1);
                    adv_end   = CW'(y1_m1);
                    adv_x     = x1;
                    adv_y     = y0_p1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            wr.wr_en    <= 1'b0;
            wr.wr_addr  <= '0;
            wr.wr_data  <= COLOUR;
            x0          <= '0;
            x1          <= '0;
            y0          <= '0;
            y1          <= '0;
`ifdef BBOX_CENTRE_EN
            cx          <= '0;
            cy          <= '0;
`endif
        end else begin
            done       <= 1'b0;
            err        <= 1'b0;
            wr.wr_data <= COLOUR;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        x0 <= x_min;
                        x1 <= x_max;
                        y0 <= y_min;
                        y1 <= y_max;
`ifdef BBOX_CENTRE_EN
                        cx <= XW'(({1'b0, x_min} + {1'b0, x_max}) >> 1);
                        cy <= YW'(({1'b0, y_min} + {1'b0, y_max}) >> 1);
`endif
                        if (box_ok) begin
                            state      <= S_TOP;
                            busy       <= 1'b1;
                            wr.wr_en   <= 1'b1;
                            wr.wr_addr <= AW'(pix_addr(x_min, y_min, IMG_W));
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: begin
                    if (accept) begin
                        if (walk_last) begin
                            state <= adv_state;
                            if (adv_state == S_DONE) begin
                                wr.wr_en <= 1'b0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                            end else begin
                                wr.wr_addr <= AW'(pix_addr(adv_x, adv_y, IMG_W));
                            end
                        end else begin
                            wr.wr_addr <= AW'(pix_addr(step_x, step_y, IMG_W));
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bbox_outline_draw.sv
// tb/tb_bbox_outline_draw.sv - directed bench with address scoreboard for bbox_outline_draw
module tb_bbox_outline_draw;

`ifdef BBOX_CENTRE_EN
    localparam int CEN = 1;
`else
    localparam int CEN = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [8:0] x_min = '0, x_max = '0;
    logic [7:0] y_min = '0, y_max = '0;
    logic       busy, done, err;
    logic       wr_ready = 1'b0;
`ifdef BBOX_CENTRE_EN
    logic [8:0] cx;
    logic [7:0] cy;
`endif

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int n_writes = 0;
    bit hold_v = 1'b0;
    int hold_a = 0;

    bbox_outline_draw_if #(.AW(17), .PIX_W(24)) wr ();
    assign wr.wr_ready = wr_ready;

    bbox_outline_draw dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .start    (start),
        .x_min    (x_min),
        .x_max    (x_max),
        .y_min    (y_min),
        .y_max    (y_max),
        .busy     (busy),
        .done     (done),
        .err      (err),
`ifdef BBOX_CENTRE_EN
        .cx       (cx),
        .cy       (cy),
`endif
        .wr       (wr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void push_model(input int xa, input int ya, input int xb, input int yb);
        for (int x = xa; x <= xb; x++) exp_q.push_back(ya * 320 + x);
        if (yb != ya)
            for (int x = xa; x <= xb; x++) exp_q.push_back(yb * 320 + x);
        for (int y = ya + 1; y < yb; y++) exp_q.push_back(y * 320 + xa);
        if (xb != xa)
            for (int y = ya + 1; y < yb; y++) exp_q.push_back(y * 320 + xb);
        if (CEN == 1) exp_q.push_back(((ya + yb) / 2) * 320 + (xa + xb) / 2);
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_wr_en", 32'(wr.wr_en), 32'd1);
                check("hold_wr_addr", 32'(wr.wr_addr), hold_a);
            end
            if (wr.wr_en) check("wr_data", 32'(wr.wr_data), 32'hFF0000);
            if (wr.wr_en && wr_ready) begin
                n_writes++;
                if (exp_q.size() == 0) check("unexpected_write", 32'(wr.wr_en), 32'd0);
                else check("wr_addr", 32'(wr.wr_addr), exp_q.pop_front());
            end
            hold_v = wr.wr_en && !wr_ready;
            hold_a = 32'(wr.wr_addr);
        end
    end

    task automatic run_box(input int xa, input int ya, input int xb, input int yb,
                           input bit stall, input bit poke, input bit exp_err,
                           input int exp_done, input int exp_n, input string tag);
        int cyc;
        n_writes = 0;
        if (!exp_err) push_model(xa, ya, xb, yb);
        @(posedge clk); #1;
        x_min = 9'(xa); y_min = 8'(ya); x_max = 9'(xb); y_max = 8'(yb);
        start = 1'b1;
        wr_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x_min = 9'd0; y_min = 8'd0; x_max = 9'd319; y_max = 8'd239;
        cyc = 1;
        wr_ready = stall ? 1'b0 : 1'b1;
        if (stall) wr_ready = ((cyc - 1) % 3 == 0);
        check({tag, "_busy_c1"}, 32'(busy), 32'(!exp_err));
        check({tag, "_wr_en_c1"}, 32'(wr.wr_en), 32'(!exp_err));
        while (!done && cyc < 200) begin
            if (poke && cyc == 3) begin
                start = 1'b1;
                x_min = 9'd0; y_min = 8'd0; x_max = 9'd2; y_max = 8'd2;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            wr_ready = stall ? ((cyc - 1) % 3 == 0) : 1'b1;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        if (exp_done > 0) check({tag, "_done_cycle"}, cyc, exp_done);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_n_writes"}, n_writes, exp_n);
        check({tag, "_queue_left"}, exp_q.size(), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wr_en", 32'(wr.wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr.wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr.wr_data), 32'hFF0000);
        reset = 1'b0;

        run_box(10, 20, 13, 22, 1'b0, 1'b0, 1'b0, 11 + CEN, 10 + CEN, "box");
        run_box(5, 5, 5, 5, 1'b0, 1'b0, 1'b0, 2 + CEN, 1 + CEN, "single");
        run_box(0, 0, 3, 0, 1'b0, 1'b0, 1'b0, 5 + CEN, 4 + CEN, "row");
        run_box(5, 0, 5, 3, 1'b0, 1'b0, 1'b0, 5 + CEN, 4 + CEN, "column");
        run_box(316, 236, 319, 239, 1'b0, 1'b0, 1'b0, 13 + CEN, 12 + CEN, "corner");
        run_box(10, 20, 13, 22, 1'b1, 1'b1, 1'b0, 0, 10 + CEN, "stall");
        run_box(8, 0, 4, 5, 1'b0, 1'b0, 1'b1, 1, 0, "bad_x_order");
        run_box(0, 0, 320, 5, 1'b0, 1'b0, 1'b1, 1, 0, "bad_x_range");
        run_box(0, 3, 5, 240, 1'b0, 1'b0, 1'b1, 1, 0, "bad_y_range");

        // Abandon the draw during the bottom edge, then redraw from scratch.
        n_writes = 0;
        push_model(10, 20, 13, 22);
        @(posedge clk); #1;
        x_min = 9'd10; y_min = 8'd20; x_max = 9'd13; y_max = 8'd22;
        start = 1'b1;
        wr_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_wr_en", 32'(wr.wr_en), 32'd1);
        check("mid_wr_addr", 32'(wr.wr_addr), 32'd7051);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_wr_en", 32'(wr.wr_en), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_n_writes", n_writes, 32'd5);
        check("rst_mid_queue", exp_q.size(), 32'(5 + CEN));
        exp_q.delete();
        reset = 1'b0;
        run_box(10, 20, 13, 22, 1'b0, 1'b0, 1'b0, 11 + CEN, 10 + CEN, "redraw");
`ifdef BBOX_CENTRE_EN
        check("centre_cx", 32'(cx), 32'd11);
        check("centre_cy", 32'(cy), 32'd21);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
